// File: rtl/huff_stream_if.sv
// huff_stream_if: symbol input stream and code-table output stream of the Huffman encoder
interface huff_stream_if #(parameter int SYM_W = 3);
  localparam int MAXL = 2 ** SYM_W - 1;
  localparam int LEN_W = $clog2(MAXL + 1);
  logic sym_valid;
  logic sym_ready;
  logic [SYM_W-1:0] sym_data;
  logic sym_last;
  logic tab_valid;
  logic tab_ready;
  logic [SYM_W-1:0] tab_sym;
  logic [LEN_W-1:0] tab_len;
  logic [MAXL-1:0] tab_code;
  logic tab_last;
  modport slave (
    input sym_valid, sym_data, sym_last, tab_ready,
    output sym_ready, tab_valid, tab_sym, tab_len, tab_code, tab_last
  );
  modport master (
    output sym_valid, sym_data, sym_last, tab_ready,
    input sym_ready, tab_valid, tab_sym, tab_len, tab_code, tab_last
  );
endinterface

// File: rtl/huff_stream_encoder.sv
// huff_stream_encoder: block histogram, iterative Huffman tree, canonical table stream (HUFF_EMIT_ZERO_EN adds unused-symbol entries)
module huff_stream_encoder #(
  parameter int SYM_W = 3,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  huff_stream_if.slave bus,
  output logic busy,
  output logic err_ovf
);
  localparam int SYMS = 2 ** SYM_W;
  localparam int NODES = 2 * SYMS - 1;
  localparam int MAXL = SYMS - 1;
  localparam int LEN_W = $clog2(MAXL + 1);
  localparam int WW = CNT_W + SYM_W;
  localparam int NW = $clog2(NODES);
  localparam int DW = SYM_W + 1;
  localparam logic [WW-1:0] SAT = WW'((1 << CNT_W) - 1);
  typedef enum logic [2:0] {COLLECT, BUILD_SCAN, BUILD_MERGE, DEPTH, EMIT, CLEAR} state_t;
  state_t state, state_n;
  logic [WW-1:0] wt [NODES];
  logic [NW-1:0] par [NODES];
  logic [LEN_W-1:0] dep [NODES];
  logic [NODES-1:0] act;
  logic [DW-1:0] d, m, cnt, d_next, total;
  logic [NW-1:0] idx, i1, i2, si, root, nxt;
  logic h1, h2, z, accept, new_sym, used, stall, hit, emit_done, scan_end;
  logic [LEN_W-1:0] l;
  logic [SYM_W-1:0] s;
  logic [MAXL-1:0] code;
  assign accept = bus.sym_valid & bus.sym_ready;
  assign si = NW'(bus.sym_data);
  assign new_sym = wt[si] == '0;
  assign d_next = d + DW'(new_sym);
  assign root = NW'(SYMS) + NW'(d) - NW'(2);
  assign nxt = NW'(SYMS) + NW'(m);
  assign used = wt[NW'(s)] != '0;
  assign stall = bus.tab_valid & ~bus.tab_ready;
  assign scan_end = s == SYM_W'(SYMS - 1);
`ifdef HUFF_EMIT_ZERO_EN
  assign total = DW'(SYMS);
`else
  assign total = d;
`endif
  assign hit = (state == EMIT) & ~stall & (cnt != total) & (z ? ~used : used & (dep[NW'(s)] == l));
  assign emit_done = bus.tab_valid & bus.tab_ready & bus.tab_last;
  assign bus.sym_ready = state == COLLECT;
  assign busy = state != COLLECT;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= COLLECT;
    else state <= state_n;
  // phase sequencing
  always_comb begin
    state_n = state;
    case (state)
      COLLECT:     if (accept & bus.sym_last) state_n = d_next < DW'(2) ? DEPTH : BUILD_SCAN;
      BUILD_SCAN:  if (idx == NW'(NODES - 1)) state_n = BUILD_MERGE;
      BUILD_MERGE: state_n = m + DW'(2) == d ? DEPTH : BUILD_SCAN;
      DEPTH:       if (idx == '0) state_n = EMIT;
      EMIT:        if (emit_done) state_n = CLEAR;
      default:     state_n = COLLECT;
    endcase
  end
  // histogram, tree construction, depth walk and canonical table output
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NODES; i++) begin
        wt[i] <= '0;
        par[i] <= '0;
        dep[i] <= '0;
      end
      act <= '0;
      err_ovf <= 1'b0;
      d <= '0;
      m <= '0;
      cnt <= '0;
      idx <= '0;
      i1 <= '0;
      i2 <= '0;
      h1 <= 1'b0;
      h2 <= 1'b0;
      z <= 1'b0;
      l <= '0;
      s <= '0;
      code <= '0;
      bus.tab_valid <= 1'b0;
      bus.tab_sym <= '0;
      bus.tab_len <= '0;
      bus.tab_code <= '0;
      bus.tab_last <= 1'b0;
    end else begin
      case (state)
        COLLECT: if (accept) begin
          if (wt[si] == SAT) err_ovf <= 1'b1;
          else wt[si] <= wt[si] + WW'(1);
          if (new_sym) begin
            d <= d_next;
            act[si] <= 1'b1;
          end
          idx <= (bus.sym_last & (d_next < DW'(2))) ? NW'(NODES - 1) : '0;
          h1 <= 1'b0;
          h2 <= 1'b0;
        end
        BUILD_SCAN: begin
          idx <= idx + NW'(1);
          if (act[idx]) begin
            if (!h1 || wt[idx] < wt[i1]) begin
              i2 <= i1;
              h2 <= h1;
              i1 <= idx;
              h1 <= 1'b1;
            end else if (!h2 || wt[idx] < wt[i2]) begin
              i2 <= idx;
              h2 <= 1'b1;
            end
          end
        end
        BUILD_MERGE: begin
          wt[nxt] <= wt[i1] + wt[i2];
          act[nxt] <= 1'b1;
          act[i1] <= 1'b0;
          act[i2] <= 1'b0;
          par[i1] <= nxt;
          par[i2] <= nxt;
          m <= m + DW'(1);
          h1 <= 1'b0;
          h2 <= 1'b0;
          idx <= m + DW'(2) == d ? NW'(NODES - 1) : '0;
        end
        DEPTH: begin
          dep[idx] <= d == DW'(1) ? LEN_W'(1) : idx == root ? '0 : dep[par[idx]] + LEN_W'(1);
          idx <= idx - NW'(1);
          l <= LEN_W'(1);
          s <= '0;
          code <= '0;
          cnt <= '0;
          z <= 1'b0;
        end
        EMIT: begin
          if (hit) begin
            bus.tab_valid <= 1'b1;
            bus.tab_sym <= s;
            bus.tab_len <= z ? '0 : l;
            bus.tab_code <= z ? '0 : code;
            bus.tab_last <= cnt + DW'(1) == total;
            cnt <= cnt + DW'(1);
          end else if (bus.tab_ready) bus.tab_valid <= 1'b0;
          if (!stall) begin
            s <= s + SYM_W'(1);
            if (!z) code <= scan_end ? (code + MAXL'(hit)) << 1 : code + MAXL'(hit);
            if (!z && scan_end) l <= l + LEN_W'(1);
`ifdef HUFF_EMIT_ZERO_EN
            if (!z && scan_end && l == LEN_W'(MAXL)) z <= 1'b1;
`endif
          end
        end
        CLEAR: begin
          for (int i = 0; i < NODES; i++) begin
            wt[i] <= '0;
            par[i] <= '0;
            dep[i] <= '0;
          end
          act <= '0;
          err_ovf <= 1'b0;
          d <= '0;
          m <= '0;
          bus.tab_valid <= 1'b0;
          bus.tab_last <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule
